// File: rtl/pt_uart_frame_rx.sv
// pt_uart_frame_rx: UART receiver (8N1, or 8E1 when PT_UART_FRAME_PARITY_EN is
// defined) that packs three bytes into a 24-bit word for the pt_enc encoder and
// paces load strobes at least FRAME_GAP cycles apart, with one pending slot.
module pt_uart_frame_rx #(
   parameter int CLKS_PER_BIT = 16,
   parameter int FRAME_GAP    = 1024,
   parameter int TIMEOUT_BITS = 20
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rx,
   output logic [23:0] ad,
   output logic        ld,
   output logic        busy,
   output logic        frame_err,
   output logic        ovf
);

   localparam int CW       = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int TO_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
   localparam int TW       = $clog2(TO_LIMIT + 1);
   localparam int GW       = $clog2(FRAME_GAP + 1);
   localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

`ifdef PT_UART_FRAME_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} state_t;
`else
   typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;
`endif

   logic          rx_meta, rxs;
   state_t        state, state_next;
   logic [CW-1:0] bit_cnt, bit_cnt_next;
   logic [2:0]    bit_idx, bit_idx_next;
   logic [7:0]    shift, shift_next;
   logic          byte_ok, byte_bad;
`ifdef PT_UART_FRAME_PARITY_EN
   logic          par_bad, par_bad_next;
`endif

   logic [15:0]   stage;
   logic [1:0]    byte_cnt;
   logic [TW-1:0] to_cnt;
   logic          to_run, timeout_hit, word_done;
   logic [23:0]   word;
   logic [GW-1:0] gap;
   logic          pend_valid;
   logic [23:0]   pend_word;

   // Two-flop synchronizer; idles high so reset never looks like a start bit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_meta <= 1'b1;
         rxs     <= 1'b1;
      end else begin
         rx_meta <= rx;
         rxs     <= rx_meta;
      end
   end

   // Receive FSM state and bit-timing registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         bit_cnt <= '0;
         bit_idx <= '0;
         shift   <= '0;
`ifdef PT_UART_FRAME_PARITY_EN
         par_bad <= 1'b0;
`endif
      end else begin
         state   <= state_next;
         bit_cnt <= bit_cnt_next;
         bit_idx <= bit_idx_next;
         shift   <= shift_next;
`ifdef PT_UART_FRAME_PARITY_EN
         par_bad <= par_bad_next;
`endif
      end
   end

   // Receive FSM next state: mid-bit sampling, LSB first, stop-bit verdict.
   always_comb begin
      state_next   = state;
      bit_cnt_next = bit_cnt;
      bit_idx_next = bit_idx;
      shift_next   = shift;
      byte_ok      = 1'b0;
      byte_bad     = 1'b0;
`ifdef PT_UART_FRAME_PARITY_EN
      par_bad_next = par_bad;
`endif
      case (state)
         IDLE: begin
            bit_cnt_next = '0;
            if (!rxs) state_next = START;
         end
         START: begin
            if (bit_cnt == HALF_LAST) begin
               bit_cnt_next = '0;
               bit_idx_next = '0;
               state_next   = rxs ? IDLE : DATA;
            end else begin
               bit_cnt_next = bit_cnt + 1'b1;
            end
         end
         DATA: begin
            if (bit_cnt == BIT_LAST) begin
               bit_cnt_next = '0;
               shift_next   = {rxs, shift[7:1]};
               bit_idx_next = bit_idx + 1'b1;
`ifdef PT_UART_FRAME_PARITY_EN
               if (bit_idx == 3'd7) state_next = PARITY;
`else
               if (bit_idx == 3'd7) state_next = STOP;
`endif
            end else begin
               bit_cnt_next = bit_cnt + 1'b1;
            end
         end
`ifdef PT_UART_FRAME_PARITY_EN
         PARITY: begin
            if (bit_cnt == BIT_LAST) begin
               bit_cnt_next = '0;
               par_bad_next = ^{rxs, shift};
               state_next   = STOP;
            end else begin
               bit_cnt_next = bit_cnt + 1'b1;
            end
         end
`endif
         STOP: begin
            if (bit_cnt == BIT_LAST) begin
               bit_cnt_next = '0;
`ifdef PT_UART_FRAME_PARITY_EN
               byte_bad = !rxs || par_bad;
`else
               byte_bad = !rxs;
`endif
               byte_ok    = !byte_bad;
               state_next = rxs ? IDLE : WAIT_HIGH;
            end else begin
               bit_cnt_next = bit_cnt + 1'b1;
            end
         end
         WAIT_HIGH: begin
            if (rxs) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   assign word        = {stage, shift};
   assign word_done   = byte_ok && (byte_cnt == 2'd2);
   assign to_run      = (state == IDLE) && rxs && (byte_cnt != 2'd0);
   assign timeout_hit = to_run && (to_cnt == TW'(TO_LIMIT - 1));

   // Frame assembler: collect bytes, drop partial frames on error or rx idle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stage    <= '0;
         byte_cnt <= '0;
         to_cnt   <= '0;
      end else begin
         if (byte_bad || timeout_hit) begin
            byte_cnt <= '0;
         end else if (byte_ok) begin
            stage    <= {stage[7:0], shift};
            byte_cnt <= (byte_cnt == 2'd2) ? 2'd0 : byte_cnt + 1'b1;
         end
         to_cnt <= (to_run && !timeout_hit) ? to_cnt + 1'b1 : '0;
      end
   end

   // Output pacing: direct load when idle, else one pending word, else drop.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ad         <= '0;
         ld         <= 1'b0;
         ovf        <= 1'b0;
         frame_err  <= 1'b0;
         gap        <= '0;
         pend_valid <= 1'b0;
         pend_word  <= '0;
      end else begin
         ld        <= 1'b0;
         ovf       <= 1'b0;
         frame_err <= byte_bad || timeout_hit;
         if (pend_valid && gap == '0) begin
            ld         <= 1'b1;
            ad         <= pend_word;
            gap        <= GW'(FRAME_GAP);
            pend_valid <= 1'b0;
         end else if (gap != '0) begin
            gap <= gap - 1'b1;
         end
         if (word_done) begin
            if (pend_valid) begin
               ovf <= 1'b1;
            end else if (gap == '0) begin
               ld  <= 1'b1;
               ad  <= word;
               gap <= GW'(FRAME_GAP);
            end else begin
               pend_valid <= 1'b1;
               pend_word  <= word;
            end
         end
      end
   end

   assign busy = (gap != '0);

endmodule
